// File: rtl/egress_drain_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// egress_drain_arbiter_pkg
//   Shared definitions for the egress drain arbiter:
//   - state_t      : FSM encoding (IDLE / ACTIVE / FLUSH)
//   - DATA_W_DEFAULT : default FIFO word width
//   - SRC_D0/SRC_D1  : source tag values carried with every buffered word
//   - rr_pick()      : round-robin choice when both sources are eligible
// ----------------------------------------------------------------------------
package egress_drain_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT = 6;

    localparam logic SRC_D0 = 1'b0;
    localparam logic SRC_D1 = 1'b1;

    // Both sources eligible: grant the one that did not win last time.
    function automatic logic rr_pick(input logic last_grant);
        return (last_grant == SRC_D1) ? SRC_D0 : SRC_D1;
    endfunction

endpackage

// File: rtl/egress_skid_fifo.sv
// ----------------------------------------------------------------------------
// egress_skid_fifo
//   Small synchronous FIFO holding tagged words ({src, data}) between the
//   pop-latency register and the output handshake.
// Ports:
//   clk, reset   clock, asynchronous active-low reset (clears pointers/count)
//   push, din    write a word (caller never pushes when full unless popping)
//   pop          remove the head word (caller never pops when empty)
//   dout         head word, valid while !empty
//   count        number of stored words (0..DEPTH)
//   empty, full  status flags
// ----------------------------------------------------------------------------
module egress_skid_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/egress_drain_arbiter.sv
// ----------------------------------------------------------------------------
// egress_drain_arbiter
//   Pops destination FIFOs D0 and D1 with round-robin arbitration and merges
//   their words into one tagged valid/ready stream.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   enable                      allow pops (ACTIVE state)
//   flush_req                   pulse: drain D0/D1 completely, ignoring almost_empty
//   data_out0/1                 FIFO read data, valid the cycle after pop
//   almost_empty_d0/1, empty_d0/1  FIFO status
//   pop_D0/pop_D1               pop strobes (combinational, same cycle as decision)
//   out_data, out_src, out_valid, out_ready  merged output stream
//   cnt_d0/cnt_d1               words delivered per source (wrap)
//   idle_out                    IDLE, buffer empty, nothing in flight
//   flush_done                  pulse on FLUSH -> IDLE
// ----------------------------------------------------------------------------
module egress_drain_arbiter
    import egress_drain_arbiter_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush_req,
    input  logic [DATA_W-1:0] data_out0,
    input  logic [DATA_W-1:0] data_out1,
    input  logic              almost_empty_d0,
    input  logic              almost_empty_d1,
    input  logic              empty_d0,
    input  logic              empty_d1,
    output logic              pop_D0,
    output logic              pop_D1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  cnt_d0,
    output logic [CNT_W-1:0]  cnt_d1,
    output logic              idle_out,
    output logic              flush_done
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    state_t            state_q;
    state_t            state_d;
    logic              last_grant_q;
    logic              infl_vld_q;
    logic              infl_src_q;
    logic [CNT_W-1:0]  cnt_d0_q;
    logic [CNT_W-1:0]  cnt_d1_q;

    logic              buf_push;
    logic              buf_pop;
    logic [DATA_W:0]   buf_din;
    logic [DATA_W:0]   buf_dout;
    logic [CW-1:0]     buf_count;
    logic              buf_empty;
    logic              buf_full;

    logic              handshake;
    logic [CW:0]       occupancy;
    logic              space;
    logic              elig0;
    logic              elig1;
    logic              grant_any;
    logic              grant_src;

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    egress_skid_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (buf_push),
        .pop   (buf_pop),
        .din   (buf_din),
        .dout  (buf_dout),
        .count (buf_count),
        .empty (buf_empty),
        .full  (buf_full)
    );

    assign handshake = !buf_empty && out_ready;
    assign buf_pop   = handshake;

    // The word popped last cycle is on data_outX now; capture it with its tag.
    // The space check at pop time guarantees room, the full guard is a backstop.
    assign buf_din  = {infl_src_q, (infl_src_q == SRC_D1) ? data_out1 : data_out0};
    assign buf_push = infl_vld_q && (!buf_full || handshake);

    assign out_valid = !buf_empty;
    assign out_data  = out_valid ? buf_dout[DATA_W-1:0] : '0;
    assign out_src   = out_valid && buf_dout[DATA_W];

    assign cnt_d0   = cnt_d0_q;
    assign cnt_d1   = cnt_d1_q;
    assign idle_out = (state_q == ST_IDLE) && buf_empty && !infl_vld_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        // Words that will occupy the buffer once the in-flight word lands and
        // this cycle's output handshake retires the head. A new pop is only
        // allowed if its word is guaranteed a slot.
        occupancy = {1'b0, buf_count} + (CW+1)'(infl_vld_q) - (CW+1)'(handshake);
        space     = (occupancy < (CW+1)'(BUF_DEPTH));

        elig0 = 1'b0;
        elig1 = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                elig0 = enable && !almost_empty_d0;
                elig1 = enable && !almost_empty_d1;
            end
            ST_FLUSH: begin
                elig0 = !empty_d0;
                elig1 = !empty_d1;
            end
            default: begin
                elig0 = 1'b0;
                elig1 = 1'b0;
            end
        endcase

        grant_any = space && (elig0 || elig1);
        if (elig0 && elig1) begin
            grant_src = rr_pick(last_grant_q);
        end else begin
            grant_src = elig1 ? SRC_D1 : SRC_D0;
        end
    end

    assign pop_D0 = grant_any && (grant_src == SRC_D0);
    assign pop_D1 = grant_any && (grant_src == SRC_D1);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                end else if (enable) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (empty_d0 && empty_d1 && !infl_vld_q && buf_empty) begin
                    state_d    = ST_IDLE;
                    flush_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, grant history, in-flight tracking, delivery counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= SRC_D1;
            infl_vld_q   <= 1'b0;
            infl_src_q   <= SRC_D0;
            cnt_d0_q     <= '0;
            cnt_d1_q     <= '0;
        end else begin
            state_q    <= state_d;
            infl_vld_q <= grant_any;
            if (grant_any) begin
                infl_src_q   <= grant_src;
                last_grant_q <= grant_src;
            end
            if (handshake) begin
                if (buf_dout[DATA_W] == SRC_D1) begin
                    cnt_d1_q <= cnt_d1_q + CNT_W'(1);
                end else begin
                    cnt_d0_q <= cnt_d0_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_egress_drain_arbiter.sv
// ----------------------------------------------------------------------------
// tb_egress_drain_arbiter
//   Directed bench: behavioural D0/D1 source FIFOs (queues) answer the pop
//   strobes one cycle later; all inputs change on the falling edge and all
//   outputs are sampled 1 time unit after it.
// ----------------------------------------------------------------------------
module tb_egress_drain_arbiter;

    localparam int DATA_W    = 6;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              flush_req;
    logic [DATA_W-1:0] data_out0;
    logic [DATA_W-1:0] data_out1;
    logic              almost_empty_d0;
    logic              almost_empty_d1;
    logic              empty_d0;
    logic              empty_d1;
    logic              pop_D0;
    logic              pop_D1;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  cnt_d0;
    logic [CNT_W-1:0]  cnt_d1;
    logic              idle_out;
    logic              flush_done;

    egress_drain_arbiter #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .flush_req       (flush_req),
        .data_out0       (data_out0),
        .data_out1       (data_out1),
        .almost_empty_d0 (almost_empty_d0),
        .almost_empty_d1 (almost_empty_d1),
        .empty_d0        (empty_d0),
        .empty_d1        (empty_d1),
        .pop_D0          (pop_D0),
        .pop_D1          (pop_D1),
        .out_data        (out_data),
        .out_src         (out_src),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .cnt_d0          (cnt_d0),
        .cnt_d1          (cnt_d1),
        .idle_out        (idle_out),
        .flush_done      (flush_done)
    );

    always #5 clk = ~clk;

    // Source FIFO models
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    int                thr0 = 0;
    int                thr1 = 0;
    bit                pend0 = 1'b0;
    bit                pend1 = 1'b0;
    int                underflow = 0;

    // Observation logs
    logic [DATA_W:0]   olog[$];
    int                poplog[$];
    int                pops0 = 0;
    int                pops1 = 0;
    int                fd_count = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        olog.delete();
        poplog.delete();
        pops0    = 0;
        pops1    = 0;
        fd_count = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        if (pend0) begin
            if (q0.size() == 0) underflow++;
            else data_out0 = q0.pop_front();
            pend0 = 1'b0;
        end
        if (pend1) begin
            if (q1.size() == 0) underflow++;
            else data_out1 = q1.pop_front();
            pend1 = 1'b0;
        end
        empty_d0        = (q0.size() == 0);
        empty_d1        = (q1.size() == 0);
        almost_empty_d0 = (q0.size() <= thr0);
        almost_empty_d1 = (q1.size() <= thr1);
        #1;
        if (pop_D0) begin pend0 = 1'b1; pops0++; poplog.push_back(0); end
        if (pop_D1) begin pend1 = 1'b1; pops1++; poplog.push_back(1); end
        if (out_valid && out_ready) olog.push_back({out_src, out_data});
        if (flush_done) fd_count++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int exp3_pop[6] = '{0, 1, 0, 1, 0, 1};
    int exp3_out[6] = '{32'h10, 32'h60, 32'h11, 32'h61, 32'h12, 32'h62};

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        flush_req = 1'b0;
        out_ready = 1'b0;
        data_out0 = '0;
        data_out1 = '0;
        @(negedge clk);
        steps(2);

        // Reset state
        check("rst_pop_D0",     32'(pop_D0),     32'h0);
        check("rst_pop_D1",     32'(pop_D1),     32'h0);
        check("rst_out_valid",  32'(out_valid),  32'h0);
        check("rst_out_data",   32'(out_data),   32'h0);
        check("rst_out_src",    32'(out_src),    32'h0);
        check("rst_cnt_d0",     32'(cnt_d0),     32'h0);
        check("rst_cnt_d1",     32'(cnt_d1),     32'h0);
        check("rst_idle_out",   32'(idle_out),   32'h1);
        check("rst_flush_done", 32'(flush_done), 32'h0);
        reset = 1'b1;
        steps(2);

        // Only D0 above its threshold
        clear_logs();
        for (int i = 1; i <= 5; i++) q0.push_back(DATA_W'(i));
        thr0 = 0; thr1 = 0;
        enable = 1'b1; out_ready = 1'b1;
        steps(14);
        check("t2_nwords", 32'(olog.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("t2_word", 32'(olog[i]), 32'(i + 1));
        check("t2_cnt_d0", 32'(cnt_d0), 32'd5);
        check("t2_pops_d1", 32'(pops1), 32'd0);
        enable = 1'b0;
        steps(2);
        check("t2_idle", 32'(idle_out), 32'h1);

        // Reset with words in flight and buffered
        q0.push_back(6'h3A); q0.push_back(6'h3B); q0.push_back(6'h3C); q0.push_back(6'h3D);
        enable = 1'b1; out_ready = 1'b0;
        steps(3);
        reset = 1'b0;
        step();
        check("t1_pop_D0",     32'(pop_D0),     32'h0);
        check("t1_out_valid",  32'(out_valid),  32'h0);
        check("t1_out_data",   32'(out_data),   32'h0);
        check("t1_cnt_d0",     32'(cnt_d0),     32'h0);
        check("t1_idle_out",   32'(idle_out),   32'h1);
        check("t1_flush_done", 32'(flush_done), 32'h0);
        reset = 1'b1; enable = 1'b0; out_ready = 1'b1;
        clear_logs();
        steps(6);
        check("t1_no_stale", 32'(olog.size()), 32'd0);
        check("t1_valid_low", 32'(out_valid), 32'h0);
        q0.delete();
        empty_d0 = 1'b1;

        // Both eligible, round-robin from D0
        clear_logs();
        q0.push_back(6'h10); q0.push_back(6'h11); q0.push_back(6'h12);
        q1.push_back(6'h20); q1.push_back(6'h21); q1.push_back(6'h22);
        enable = 1'b1; out_ready = 1'b1;
        steps(12);
        check("t3_npops", 32'(poplog.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("t3_pop_order", 32'(poplog[i]), 32'(exp3_pop[i]));
        check("t3_nwords", 32'(olog.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("t3_word", 32'(olog[i]), 32'(exp3_out[i]));
        check("t3_cnt_d0", 32'(cnt_d0), 32'd3);
        check("t3_cnt_d1", 32'(cnt_d1), 32'd3);
        enable = 1'b0;
        steps(3);

        // Consumer stalled: buffer fills, pops stop, head holds
        clear_logs();
        q0.push_back(6'h31); q0.push_back(6'h32); q0.push_back(6'h33);
        enable = 1'b1; out_ready = 1'b0;
        steps(11);
        check("t4_pops", 32'(pops0), 32'd2);
        check("t4_pop_D0_low", 32'(pop_D0), 32'h0);
        check("t4_pop_D1_low", 32'(pop_D1), 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 32'(out_valid), 32'h1);
            check("t4_hold_data", 32'(out_data), 32'h31);
            step();
        end
        check("t4_pops_after", 32'(pops0), 32'd2);
        enable = 1'b0;
        step();
        out_ready = 1'b1;
        steps(4);
        check("t4_nwords", 32'(olog.size()), 32'd2);
        check("t4_word0", 32'(olog[0]), 32'h31);
        check("t4_word1", 32'(olog[1]), 32'h32);
        check("t4_cnt_d0", 32'(cnt_d0), 32'd5);
        check("t4_idle", 32'(idle_out), 32'h1);

        // Flush drains a word held back by almost_empty
        clear_logs();
        thr0 = 1;
        enable = 1'b1;
        steps(4);
        check("t5_ae_blocks", 32'(pops0), 32'd0);
        enable = 1'b0; flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        steps(8);
        check("t5_pops", 32'(pops0), 32'd1);
        check("t5_nwords", 32'(olog.size()), 32'd1);
        check("t5_word", 32'(olog[0]), 32'h33);
        check("t5_flush_done_pulses", 32'(fd_count), 32'd1);
        check("t5_idle", 32'(idle_out), 32'h1);
        check("t5_cnt_d0", 32'(cnt_d0), 32'd6);

        // cnt_d1 wrap
        reset = 1'b0;
        step();
        reset = 1'b1;
        clear_logs();
        thr0 = 0; thr1 = 0;
        for (int i = 0; i < 255; i++) q1.push_back(DATA_W'(i));
        enable = 1'b1; out_ready = 1'b1;
        steps(270);
        check("t6_cnt_d1_ff", 32'(cnt_d1), 32'hFF);
        check("t6_cnt_d0", 32'(cnt_d0), 32'h0);
        q1.push_back(6'h2A);
        steps(8);
        check("t6_cnt_d1_wrap", 32'(cnt_d1), 32'h0);
        check("t6_last_word", 32'(olog[olog.size() - 1]), 32'h6A);
        enable = 1'b0;
        steps(2);

        check("no_underflow", 32'(underflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
